// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALUOP classes, funct codes, ALU op codes.
// Included by alu_ctrl_dec and alu_execute.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 6;

   // ALUOP classes from the main control unit
   localparam logic [OP_W-1:0] ALUOP_ADD   = 6'd0;
   localparam logic [OP_W-1:0] ALUOP_SUB   = 6'd1;
   localparam logic [OP_W-1:0] ALUOP_FUNCT = 6'd2;
   localparam logic [OP_W-1:0] ALUOP_AND   = 6'd3;
   localparam logic [OP_W-1:0] ALUOP_OR    = 6'd4;
   localparam logic [OP_W-1:0] ALUOP_SLT   = 6'd5;
   localparam logic [OP_W-1:0] ALUOP_XOR   = 6'd6;
   localparam logic [OP_W-1:0] ALUOP_LUI   = 6'd7;

   // R-type funct field values
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // ALU operation codes
   localparam logic [OP_W-1:0] OP_AND     = 6'd0;
   localparam logic [OP_W-1:0] OP_OR      = 6'd1;
   localparam logic [OP_W-1:0] OP_ADD     = 6'd2;
   localparam logic [OP_W-1:0] OP_XOR     = 6'd3;
   localparam logic [OP_W-1:0] OP_SUB     = 6'd6;
   localparam logic [OP_W-1:0] OP_SLT     = 6'd7;
   localparam logic [OP_W-1:0] OP_SLL     = 6'd8;
   localparam logic [OP_W-1:0] OP_SRL     = 6'd9;
   localparam logic [OP_W-1:0] OP_SRA     = 6'd10;
   localparam logic [OP_W-1:0] OP_NOR     = 6'd12;
   localparam logic [OP_W-1:0] OP_LUI     = 6'd13;
   localparam logic [OP_W-1:0] OP_SLTU    = 6'd14;
   localparam logic [OP_W-1:0] OP_INVALID = 6'd63;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: ALUOP class + funct -> ALU op code. Shift ops only with ALU_SHIFT_EN.
// Latency: combinational. Backpressure: none.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [OP_W-1:0] alu_op,
   input  logic [5:0]      func,
   output logic [OP_W-1:0] op
);

   logic [OP_W-1:0] funct_op;

   always_comb begin
      funct_op = OP_INVALID;
      case (func)
         FN_ADD, FN_ADDU: funct_op = OP_ADD;
         FN_SUB, FN_SUBU: funct_op = OP_SUB;
         FN_AND:          funct_op = OP_AND;
         FN_OR:           funct_op = OP_OR;
         FN_XOR:          funct_op = OP_XOR;
         FN_NOR:          funct_op = OP_NOR;
         FN_SLT:          funct_op = OP_SLT;
         FN_SLTU:         funct_op = OP_SLTU;
`ifdef ALU_SHIFT_EN
         FN_SLL:          funct_op = OP_SLL;
         FN_SRL:          funct_op = OP_SRL;
         FN_SRA:          funct_op = OP_SRA;
`endif
         default:         funct_op = OP_INVALID;
      endcase
   end

   always_comb begin
      op = OP_INVALID;
      case (alu_op)
         ALUOP_ADD:   op = OP_ADD;
         ALUOP_SUB:   op = OP_SUB;
         ALUOP_FUNCT: op = funct_op;
         ALUOP_AND:   op = OP_AND;
         ALUOP_OR:    op = OP_OR;
         ALUOP_SLT:   op = OP_SLT;
         ALUOP_XOR:   op = OP_XOR;
         ALUOP_LUI:   op = OP_LUI;
         default:     op = OP_INVALID;
      endcase
   end

endmodule

// File: rtl/alu_execute.sv
// Execute stage: PC+4, ALU control decode, 32-bit ALU; shifter present only with ALU_SHIFT_EN.
// Latency: outputs combinational, *_q copies one cycle later. Backpressure: none.
module alu_execute
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] pc_end,
   input  logic [OP_W-1:0]   ALUOP,
   input  logic [5:0]        func,
   output logic [OP_W-1:0]   alu_control_out,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   output logic [DATA_W-1:0] ALU_result,
   output logic              zero,
   output logic [DATA_W-1:0] ALU_result_q,
   output logic              zero_q
);

   assign pc_end = pc + 32'd4;

   alu_ctrl_dec u_ctrl_dec (
      .alu_op (ALUOP),
      .func   (func),
      .op     (alu_control_out)
   );

   always_comb begin
      ALU_result = '0;
      case (alu_control_out)
         OP_ADD:  ALU_result = read_data1 + read_data2;
         OP_SUB:  ALU_result = read_data1 - read_data2;
         OP_AND:  ALU_result = read_data1 & read_data2;
         OP_OR:   ALU_result = read_data1 | read_data2;
         OP_XOR:  ALU_result = read_data1 ^ read_data2;
         OP_NOR:  ALU_result = ~(read_data1 | read_data2);
         OP_SLT:  ALU_result = {31'd0, $signed(read_data1) < $signed(read_data2)};
         OP_SLTU: ALU_result = {31'd0, read_data1 < read_data2};
         OP_LUI:  ALU_result = {read_data2[15:0], 16'h0000};
`ifdef ALU_SHIFT_EN
         // shift amount comes from operand A, the value shifted is operand B
         OP_SLL:  ALU_result = read_data2 << read_data1[4:0];
         OP_SRL:  ALU_result = read_data2 >> read_data1[4:0];
         OP_SRA:  ALU_result = $unsigned($signed(read_data2) >>> read_data1[4:0]);
`endif
         default: ALU_result = '0;
      endcase
   end

   assign zero = (ALU_result == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         ALU_result_q <= '0;
         zero_q       <= 1'b0;
      end else begin
         ALU_result_q <= ALU_result;
         zero_q       <= zero;
      end
   end

endmodule

// File: tb/tb_alu_execute.sv
// Directed self-checking bench for alu_execute; expectations follow ALU_SHIFT_EN when defined.
module tb_alu_execute;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] pc_end;
   logic [5:0]  ALUOP;
   logic [5:0]  func;
   logic [5:0]  alu_control_out;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [31:0] ALU_result;
   logic        zero;
   logic [31:0] ALU_result_q;
   logic        zero_q;

   int n_cmp = 0;
   int n_err = 0;

   alu_execute dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .pc_end          (pc_end),
      .ALUOP           (ALUOP),
      .func            (func),
      .alu_control_out (alu_control_out),
      .read_data1      (read_data1),
      .read_data2      (read_data2),
      .ALU_result      (ALU_result),
      .zero            (zero),
      .ALU_result_q    (ALU_result_q),
      .zero_q          (zero_q)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [5:0] aop, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      ALUOP = aop; func = fn; read_data1 = a; read_data2 = b;
      #1;
   endtask

   // Compare op, result and zero against hand-computed values.
   task automatic check_alu(input string name, input logic [5:0] e_op,
                            input logic [31:0] e_res, input logic e_zero);
      n_cmp++;
      if (alu_control_out !== e_op) begin
         n_err++;
         $display("FAIL %s op: got %0d want %0d", name, alu_control_out, e_op);
      end
      n_cmp++;
      if (ALU_result !== e_res) begin
         n_err++;
         $display("FAIL %s result: got %h want %h", name, ALU_result, e_res);
      end
      n_cmp++;
      if (zero !== e_zero) begin
         n_err++;
         $display("FAIL %s zero: got %b want %b", name, zero, e_zero);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      pc = 32'h0;
      drive(6'd2, 6'h20, 32'd5, 32'd7);
      @(posedge clk); @(posedge clk); #1;
      n_cmp++;
      if (ALU_result_q !== 32'h0) begin
         n_err++;
         $display("FAIL reset_q: got %h want 00000000", ALU_result_q);
      end
      n_cmp++;
      if (zero_q !== 1'b0) begin
         n_err++;
         $display("FAIL reset_zero_q: got %b want 0", zero_q);
      end
      reset = 1'b0;
   endtask

   task automatic test_pc;
      logic [31:0] pcs [3];
      logic [31:0] exp [3];
      pcs = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0040_0010};
      exp = '{32'h0000_0004, 32'h0000_0000, 32'h0040_0014};
      for (int i = 0; i < 3; i++) begin
         pc = pcs[i];
         #1;
         n_cmp++;
         if (pc_end !== exp[i]) begin
            n_err++;
            $display("FAIL pc_end[%0d]: got %h want %h", i, pc_end, exp[i]);
         end
      end
   endtask

   task automatic test_add;
      drive(6'd2, 6'h20, 32'd5, 32'd7);
      check_alu("add", 6'd2, 32'd12, 1'b0);
      @(posedge clk); #1;
      n_cmp++;
      if (ALU_result_q !== 32'd12) begin
         n_err++;
         $display("FAIL add_q: got %h want 0000000c", ALU_result_q);
      end
      drive(6'd2, 6'h21, 32'd100, 32'd23);
      check_alu("addu", 6'd2, 32'd123, 1'b0);
      drive(6'd0, 6'h3F, 32'hFFFF_FFFF, 32'd1);
      check_alu("add_wrap", 6'd2, 32'h0, 1'b1);
   endtask

   task automatic test_sub_beq;
      drive(6'd1, 6'h00, 32'h1234, 32'h1234);
      check_alu("beq", 6'd6, 32'h0, 1'b1);
      @(posedge clk); #1;
      n_cmp++;
      if (zero_q !== 1'b1) begin
         n_err++;
         $display("FAIL beq_zero_q: got %b want 1", zero_q);
      end
      drive(6'd2, 6'h22, 32'd3, 32'd5);
      check_alu("sub_neg", 6'd6, 32'hFFFF_FFFE, 1'b0);
      drive(6'd2, 6'h23, 32'd9, 32'd4);
      check_alu("subu", 6'd6, 32'd5, 1'b0);
   endtask

   task automatic test_logic;
      drive(6'd3, 6'h00, 32'hF0F0_FF00, 32'h0FF0_0FF0);
      check_alu("and", 6'd0, 32'h00F0_0F00, 1'b0);
      drive(6'd4, 6'h00, 32'hF0F0_FF00, 32'h0FF0_0FF0);
      check_alu("or", 6'd1, 32'hFFF0_FFF0, 1'b0);
      drive(6'd6, 6'h00, 32'hF0F0_FF00, 32'h0FF0_0FF0);
      check_alu("xor", 6'd3, 32'hFF00_F0F0, 1'b0);
      drive(6'd2, 6'h27, 32'hF0F0_FF00, 32'h0FF0_0FF0);
      check_alu("nor", 6'd12, 32'h000F_000F, 1'b0);
      drive(6'd2, 6'h24, 32'hF0F0_FF00, 32'h0F0F_00FF);
      check_alu("and_funct", 6'd0, 32'h0, 1'b1);
      drive(6'd7, 6'h00, 32'hDEAD_BEEF, 32'h1234_ABCD);
      check_alu("lui", 6'd13, 32'hABCD_0000, 1'b0);
   endtask

   task automatic test_slt;
      drive(6'd2, 6'h2A, 32'hFFFF_FFFF, 32'd1);
      check_alu("slt", 6'd7, 32'd1, 1'b0);
      drive(6'd2, 6'h2B, 32'hFFFF_FFFF, 32'd1);
      check_alu("sltu", 6'd14, 32'd0, 1'b1);
      drive(6'd5, 6'h00, 32'd1, 32'hFFFF_FFFF);
      check_alu("slti_pos_vs_neg", 6'd7, 32'd0, 1'b1);
      drive(6'd2, 6'h2B, 32'd1, 32'hFFFF_FFFF);
      check_alu("sltu_small", 6'd14, 32'd1, 1'b0);
   endtask

   task automatic test_shift;
`ifdef ALU_SHIFT_EN
      drive(6'd2, 6'h03, 32'd4, 32'h8000_0000);
      check_alu("sra", 6'd10, 32'hF800_0000, 1'b0);
      drive(6'd2, 6'h02, 32'd4, 32'h8000_0000);
      check_alu("srl", 6'd9, 32'h0800_0000, 1'b0);
      drive(6'd2, 6'h00, 32'h0000_0024, 32'd1);
      check_alu("sll_amt5", 6'd8, 32'h0000_0010, 1'b0);
`else
      drive(6'd2, 6'h03, 32'd4, 32'h8000_0000);
      check_alu("sra_off", 6'd63, 32'h0, 1'b1);
      drive(6'd2, 6'h02, 32'd4, 32'h8000_0000);
      check_alu("srl_off", 6'd63, 32'h0, 1'b1);
      drive(6'd2, 6'h00, 32'h0000_0024, 32'd1);
      check_alu("sll_off", 6'd63, 32'h0, 1'b1);
`endif
   endtask

   task automatic test_invalid;
      drive(6'd8, 6'h20, 32'd5, 32'd7);
      check_alu("aluop8", 6'd63, 32'h0, 1'b1);
      drive(6'd63, 6'h20, 32'd5, 32'd7);
      check_alu("aluop63", 6'd63, 32'h0, 1'b1);
      drive(6'd2, 6'h3F, 32'd5, 32'd7);
      check_alu("funct3f", 6'd63, 32'h0, 1'b1);
   endtask

   task automatic test_reset_hold;
      drive(6'd2, 6'h20, 32'd5, 32'd7);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (ALU_result_q !== 32'h0) begin
         n_err++;
         $display("FAIL rst_hold_q: got %h want 00000000", ALU_result_q);
      end
      n_cmp++;
      if (zero_q !== 1'b0) begin
         n_err++;
         $display("FAIL rst_hold_zero_q: got %b want 0", zero_q);
      end
      n_cmp++;
      if (ALU_result !== 32'd12) begin
         n_err++;
         $display("FAIL rst_hold_comb: got %h want 0000000c", ALU_result);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (ALU_result_q !== 32'd12) begin
         n_err++;
         $display("FAIL rst_release_q: got %h want 0000000c", ALU_result_q);
      end
   endtask

   task automatic test_back_to_back;
      drive(6'd2, 6'h20, 32'd1, 32'd2);
      @(posedge clk); #1;
      drive(6'd4, 6'h00, 32'hA0, 32'h0B);
      n_cmp++;
      if (ALU_result_q !== 32'd3) begin
         n_err++;
         $display("FAIL b2b_q0: got %h want 00000003", ALU_result_q);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ALU_result_q !== 32'hAB) begin
         n_err++;
         $display("FAIL b2b_q1: got %h want 000000ab", ALU_result_q);
      end
   endtask

   initial begin
      test_reset();
      test_pc();
      test_add();
      test_sub_beq();
      test_logic();
      test_slt();
      test_shift();
      test_invalid();
      test_reset_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
